// File: rtl/timer_pkg.sv
// Shared constants, converter state type and the double-dabble digit correction
// used by the timer output sink.
package timer_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned BCD_W      = 4;
    localparam int unsigned DD_THRESH  = 5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_e;

    // Pre-shift correction so a nibble of 5..9 carries correctly once doubled.
    function automatic logic [BCD_W-1:0] dd_correct(input logic [BCD_W-1:0] nib);
        return (nib >= BCD_W'(DD_THRESH)) ? nib + BCD_W'(3) : nib;
    endfunction

endpackage

// File: rtl/timer_sink_if.sv
// Timer-to-sink link: enable from the sink, qualified data words from the timer.
interface timer_sink_if #(
    parameter int unsigned DATA_W = 16
);
    logic              t_en;
    logic              t_valid;
    logic [DATA_W-1:0] t_out;

    modport master (output t_valid, output t_out, input  t_en);
    modport slave  (input  t_valid, input  t_out, output t_en);
endinterface

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO; a push into a full FIFO is accepted only when a pop
// happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             push_fire, pop_fire;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CntW'(DEPTH));
    assign count     = count_q;
    assign rdata     = mem[rd_ptr_q];
    assign pop_fire  = pop && !empty;
    assign push_fire = push && (!full || pop_fire);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_fire)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_fire, pop_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_fire) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/timer_sink.sv
// Timer consumer: run/stop toggle, capture FIFO with sticky overflow, and a
// sequential binary-to-BCD converter feeding the display path.
module timer_sink
    import timer_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned NDIG       = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_btn,
    timer_sink_if.slave            tif,
    output logic [BCD_W*NDIG-1:0]  bcd_out,
    output logic                   bcd_valid,
    output logic                   busy,
    output logic                   ovf,
    input  logic                   ovf_clr
);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned IdxW = $clog2(DATA_W + 1);
    localparam int unsigned BcdW = BCD_W * NDIG;

    logic btn_q, run_q, ovf_q;

    logic              fifo_pop, fifo_full, fifo_empty, drop;
    logic [DATA_W-1:0] fifo_rdata;
    logic [CntW-1:0]   fifo_count;

    conv_state_e       state_q, state_d;
    logic [BcdW-1:0]   acc_q, acc_d, acc_corr;
    logic [DATA_W-1:0] bin_q, bin_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;
    logic              valid_q, valid_d;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tif.t_valid),
        .wdata (tif.t_out),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Words arriving when full are lost unless the converter frees a slot this cycle.
    assign drop = tif.t_valid && fifo_full && !fifo_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_q <= 1'b0;
            run_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            btn_q <= start_btn;
            if (start_btn && !btn_q) run_q <= ~run_q;
            if (drop)         ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

    always_comb begin
        acc_corr = acc_q;
        for (int d = 0; d < int'(NDIG); d++) begin
            acc_corr[d*BCD_W +: BCD_W] = dd_correct(acc_q[d*BCD_W +: BCD_W]);
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        bin_d    = bin_q;
        idx_d    = idx_q;
        bcd_d    = bcd_q;
        valid_d  = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    acc_d    = '0;
                    bin_d    = fifo_rdata;
                    idx_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = {acc_corr[BcdW-2:0], bin_q[DATA_W-1]};
                bin_d = {bin_q[DATA_W-2:0], 1'b0};
                idx_d = idx_q + 1'b1;
                if (idx_q == IdxW'(DATA_W - 1)) state_d = DONE;
            end
            DONE: begin
                bcd_d   = acc_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            bin_q   <= '0;
            idx_q   <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            bin_q   <= bin_d;
            idx_q   <= idx_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
        end
    end

    assign tif.t_en  = run_q;
    assign bcd_out   = bcd_q;
    assign bcd_valid = valid_q;
    assign busy      = (state_q != IDLE);
    assign ovf       = ovf_q;

    occupancy_bound: assert property (@(posedge clk) disable iff (!rst)
        fifo_count <= CntW'(FIFO_DEPTH));

endmodule

// File: tb/tb_timer_sink.sv
// Directed bench for timer_sink: run toggle, conversions, overflow, full-with-pop
// acceptance and asynchronous reset mid-conversion.
module tb_timer_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_btn;
    logic        ovf_clr;
    logic [19:0] bcd_out;
    logic        bcd_valid, busy, ovf;

    int n_vec = 0;
    int n_err = 0;

    timer_sink_if #(.DATA_W(16)) tif ();

    timer_sink dut (
        .clk       (clk),
        .rst       (rst),
        .start_btn (start_btn),
        .tif       (tif),
        .bcd_out   (bcd_out),
        .bcd_valid (bcd_valid),
        .busy      (busy),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits up to `limit` cycles for a bcd_valid pulse; returns cycles waited.
    task automatic wait_valid(input int limit, output int waited);
        waited = 0;
        while (!bcd_valid && waited < limit) begin
            @(negedge clk);
            waited++;
        end
    endtask

    task automatic convert_one(input logic [15:0] w, input logic [19:0] exp, input string tag);
        int lat;
        lat = 0;
        tif.t_valid = 1'b1;
        tif.t_out   = w;
        @(negedge clk);
        tif.t_valid = 1'b0;
        while (!bcd_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 1 || lat == 17) check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'd18);
        check_eq({tag, "_bcd"}, 32'(bcd_out), 32'(exp));
        @(negedge clk);
        check_eq({tag, "_pulse1"}, 32'(bcd_valid), 32'd0);
        check_eq({tag, "_hold"}, 32'(bcd_out), 32'(exp));
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, cyc, pulses;
        logic [19:0] exp_q [$];

        rst = 1'b0; start_btn = 1'b0; ovf_clr = 1'b0;
        tif.t_valid = 1'b0; tif.t_out = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ten",   32'(tif.t_en), 32'd0);
        check_eq("rst_busy",  32'(busy),     32'd0);
        check_eq("rst_valid", 32'(bcd_valid), 32'd0);
        check_eq("rst_bcd",   32'(bcd_out),  32'd0);
        check_eq("rst_ovf",   32'(ovf),      32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Run toggle: held button toggles once, second press stops.
        start_btn = 1'b1;
        @(negedge clk);
        check_eq("ten_on", 32'(tif.t_en), 32'd1);
        repeat (2) @(negedge clk);
        check_eq("ten_held", 32'(tif.t_en), 32'd1);
        start_btn = 1'b0;
        @(negedge clk);
        check_eq("ten_rel", 32'(tif.t_en), 32'd1);
        start_btn = 1'b1;
        @(negedge clk);
        check_eq("ten_off", 32'(tif.t_en), 32'd0);
        start_btn = 1'b0;
        @(negedge clk);

        convert_one(16'd1234,  20'h01234, "c1234");
        convert_one(16'hFFFF,  20'h65535, "cffff");
        convert_one(16'd0,     20'h00000, "czero");
        convert_one(16'd9999,  20'h09999, "c9999");
        convert_one(16'd10000, 20'h10000, "c10000");

        // Six back-to-back words: 1 goes straight to the converter, 2..5 fill, 6 drops.
        for (int i = 1; i <= 6; i++) begin
            tif.t_valid = 1'b1;
            tif.t_out   = 16'(i);
            ovf_clr     = (i == 6);
            @(negedge clk);
        end
        tif.t_valid = 1'b0;
        ovf_clr     = 1'b0;
        check_eq("ovf_drop_prio", 32'(ovf), 32'd1);
        cyc = 5;
        for (int j = 0; j < 5; j++) begin
            wait_valid(40, w);
            cyc += w;
            check_eq($sformatf("burst_t%0d", j + 1), 32'(cyc), 32'(18 * (j + 1)));
            check_eq($sformatf("burst_v%0d", j + 1), 32'(bcd_out), 32'(j + 1));
            @(negedge clk);
            cyc++;
        end
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bcd_valid) pulses++;
        end
        check_eq("burst_no6", 32'(pulses), 32'd0);
        check_eq("ovf_sticky", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check_eq("ovf_clr", 32'(ovf), 32'd0);

        // Full FIFO plus a pop in the same cycle must accept the new word.
        exp_q = '{20'h00022, 20'h00033, 20'h00044, 20'h00055, 20'h00066};
        tif.t_valid = 1'b1; tif.t_out = 16'd11;
        @(negedge clk);
        tif.t_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            tif.t_valid = 1'b1;
            tif.t_out   = 16'(22 + 11 * i);
            @(negedge clk);
        end
        tif.t_valid = 1'b0;
        wait_valid(40, w);
        check_eq("fwp_first", 32'(bcd_out), 32'h11);
        tif.t_valid = 1'b1; tif.t_out = 16'd66;
        @(negedge clk);
        tif.t_valid = 1'b0;
        check_eq("fwp_ovf", 32'(ovf), 32'd0);
        for (int j = 0; j < 5; j++) begin
            wait_valid(40, w);
            check_eq($sformatf("fwp_v%0d", j), 32'(bcd_out), 32'(exp_q[j]));
            @(negedge clk);
        end
        check_eq("fwp_ovf_end", 32'(ovf), 32'd0);

        // Reset mid-conversion with a second word still queued.
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
        check_eq("ten_rerun", 32'(tif.t_en), 32'd1);
        tif.t_valid = 1'b1; tif.t_out = 16'd4321;
        @(negedge clk);
        tif.t_valid = 1'b0;
        @(negedge clk);
        tif.t_valid = 1'b1; tif.t_out = 16'd77;
        @(negedge clk);
        tif.t_valid = 1'b0;
        repeat (7) @(negedge clk);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("arst_busy",  32'(busy),      32'd0);
        check_eq("arst_bcd",   32'(bcd_out),   32'd0);
        check_eq("arst_valid", 32'(bcd_valid), 32'd0);
        check_eq("arst_ten",   32'(tif.t_en),  32'd0);
        check_eq("arst_ovf",   32'(ovf),       32'd0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bcd_valid || busy) pulses++;
        end
        check_eq("arst_quiet", 32'(pulses), 32'd0);
        check_eq("arst_hold_bcd", 32'(bcd_out), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
